sap_control_sequencer: RTL
==========================

# sap_control_sequencer

Instruction sequencer for the SAP-1 datapath. It runs a six-state T-state ring counter (fetch T1–T3, execute T4–T6) and decodes the ring state plus the 4-bit opcode from the instruction register. The result is the 12-bit control word that drives the bus mux and the register load enables in the top level. It also detects HLT and freezes the machine until reset.

## Interface
Parameters:
- none

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- clr_  input  1  reset, synchronous, active-low
- opcode  input  4  IR upper nibble; stable from the end of T3 through T6
- con  output  12  control word {cp, ep, lm_, ce_, li_, ei_, la_, ea, su, eu, lb_, lo_}, bit 11 = cp
- t_state  output  6  one-hot ring state, bit0 = T1 … bit5 = T6; 6'b000000 while halted
- instr_done  output  1  high during the final T-state of each instruction
- halted  output  1  high once HLT is executed; held until reset

## Operation
- State register: ring {T1..T6} plus a HALT state. Next state is T(n+1), and T6 wraps to T1. T4 with opcode 4'hF goes to HALT. HALT stays in HALT.
- con is a combinational decode of the registered state and opcode. There are no extra pipeline stages.
- Idle word IDLE = 12'h3E3: all active-low enables high and all active-high signals low. It is driven in every T-state not listed below, in HALT, and whenever clr_ = 0.
- Fetch, all opcodes:
  - T1: ep = 1, lm_ = 0. Value 12'h5E3.
  - T2: cp = 1. Value 12'hBE3.
  - T3: ce_ = 0, li_ = 0. Value 12'h263.
- LDA, 4'h0:
  - T4: ei_ = 0, lm_ = 0. Value 12'h1A3.
  - T5: ce_ = 0, la_ = 0. Value 12'h2C3.
  - T6: IDLE.
- ADD, 4'h1:
  - T4: same as LDA T4 (12'h1A3).
  - T5: ce_ = 0, lb_ = 0. Value 12'h2E1.
  - T6: eu = 1, la_ = 0. Value 12'h3C7.
- SUB, 4'h2: same as ADD, except T6 also sets su = 1. Value 12'h3CF.
- OUT, 4'hE:
  - T4: ea = 1, lo_ = 0. Value 12'h3F2.
  - T5 and T6: IDLE.
- HLT, 4'hF:
  - T4: IDLE.
  - The state moves to HALT at the end of T4.
  - halted goes high from the next cycle on.
- Any other opcode is a NOP: T4–T6 are IDLE.
- Bus-select invariant: {ep, ce_, ei_, ea, eu} only ever takes the values 11100, 00100, 01000, 01110, 01101, or the idle value 01100. No two bus drivers are ever enabled together.
- instr_done is high in:
  - T6 for every non-HLT opcode (or in the shortened last state, see Configuration);
  - T4 for HLT.

## Timing
- Reset:
  - clr_ = 0 at a rising edge sets state to T1 and halted to 0.
  - While clr_ = 0: con = 12'h3E3, instr_done = 0, t_state = 6'b000001.
  - The first cycle after clr_ is released is T1.
- Reset mid-instruction, or while halted: the next state is T1 regardless of the current state. No partial execute state is retained.
- Latency: each control word acts at the rising edge that ends its T-state. The IR loads at the end of T3, so opcode is first decoded in T4.
- Without shortening, every non-HLT instruction takes exactly 6 cycles, T1 to T1.
- HALT: t_state = 0, con = IDLE, instr_done = 0, halted = 1. Only clr_ exits.
- Opcode is sampled combinationally in T4–T6 only. Opcode changes during T1–T3 must not affect con.

## Configuration
- SAP_CTRL_SHORT_CYCLE_EN defined: instructions skip their trailing idle T-states.
  - LDA returns to T1 after T5, so instr_done is in T5 (5 cycles).
  - OUT and NOP return to T1 after T4, so instr_done is in T4 (4 cycles).
  - ADD and SUB are unchanged (6 cycles).
  - HLT is unchanged.
- Not defined: fixed six-state ring for all non-HLT opcodes. The state after T4/T5 is always T(n+1).

## Test plan
- Reset then run with opcode = 4'h0: con sequence from the first post-reset cycle is 5E3, BE3, 263, 1A3, 2C3, 3E3, then 5E3. t_state is one-hot 1, 2, 4, 8, 16, 32. instr_done is high only in T6.
- ADD then SUB, with opcode changed during T1–T3 of the SUB: T4–T6 give 1A3, 2E1, 3C7, then 1A3, 2E1, 3CF. Nothing glitches on the opcode change.
- OUT (4'hE): T4 con = 3F2, T5 and T6 are 3E3. Check the bus-select field against the legal set every cycle.
- HLT (4'hF): T4 con = 3E3 with instr_done = 1. From the next cycle on, halted = 1, t_state = 0, con = 3E3. This holds for 20 or more cycles.
- Reset mid-operation: assert clr_ = 0 during T5 of an ADD, then during HALT. Each time the next cycle shows con = 3E3, t_state = 1, halted = 0. The cycle after release shows con = 5E3.
- With SAP_CTRL_SHORT_CYCLE_EN: LDA repeats every 5 cycles, OUT and an opcode-4'h7 NOP every 4, ADD every 6. instr_done marks the last state of each.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// SAP-1 T-state ring sequencer and control-word decoder with HLT detection.
// Define SAP_CTRL_SHORT_CYCLE_EN to skip trailing idle execute states.
module sap_control_sequencer (
  input  logic        clk,
  input  logic        clr_,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit order: {cp, ep, lm_, ce_, li_, ei_, la_, ea, su, eu, lb_, lo_}
  localparam logic [11:0] CW_IDLE    = 12'h3E3;
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;
  localparam logic [11:0] CW_FETCH3  = 12'h263;
  localparam logic [11:0] CW_ADDR    = 12'h1A3;
  localparam logic [11:0] CW_LDA_T5  = 12'h2C3;
  localparam logic [11:0] CW_ALU_T5  = 12'h2E1;
  localparam logic [11:0] CW_ADD_T6  = 12'h3C7;
  localparam logic [11:0] CW_SUB_T6  = 12'h3CF;
  localparam logic [11:0] CW_OUT_T4  = 12'h3F2;

  state_e state_q, state_d;
  state_e run_next;
  logic   last_state;
  logic   op_is_alu;

  assign op_is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // last_state flags the state whose successor starts a new fetch or halts
  always_comb begin
    run_next   = state_q;
    last_state = 1'b0;
    case (state_q)
      S_T1: run_next = S_T2;
      S_T2: run_next = S_T3;
      S_T3: run_next = S_T4;
      S_T4: begin
        if (opcode == OP_HLT) begin
          run_next   = S_HALT;
          last_state = 1'b1;
        end else begin
`ifdef SAP_CTRL_SHORT_CYCLE_EN
          if ((opcode == OP_LDA) || op_is_alu) begin
            run_next = S_T5;
          end else begin
            run_next   = S_T1;
            last_state = 1'b1;
          end
`else
          run_next = S_T5;
`endif
        end
      end
      S_T5: begin
`ifdef SAP_CTRL_SHORT_CYCLE_EN
        if (opcode == OP_LDA) begin
          run_next   = S_T1;
          last_state = 1'b1;
        end else begin
          run_next = S_T6;
        end
`else
        run_next = S_T6;
`endif
      end
      S_T6: begin
        run_next   = S_T1;
        last_state = 1'b1;
      end
      S_HALT: run_next = S_HALT;
      default: run_next = S_T1;
    endcase
    state_d = clr_ ? run_next : S_T1;
  end

  always_comb begin
    con = CW_IDLE;
    if (clr_) begin
      case (state_q)
        S_T1: con = CW_FETCH1;
        S_T2: con = CW_FETCH2;
        S_T3: con = CW_FETCH3;
        S_T4: begin
          if ((opcode == OP_LDA) || op_is_alu) con = CW_ADDR;
          else if (opcode == OP_OUT)           con = CW_OUT_T4;
        end
        S_T5: begin
          if (opcode == OP_LDA) con = CW_LDA_T5;
          else if (op_is_alu)   con = CW_ALU_T5;
        end
        S_T6: begin
          if (opcode == OP_ADD)      con = CW_ADD_T6;
          else if (opcode == OP_SUB) con = CW_SUB_T6;
        end
        default: con = CW_IDLE;
      endcase
    end
  end

  always_comb begin
    t_state = 6'b000001;
    if (clr_) begin
      case (state_q)
        S_T1:    t_state = 6'b000001;
        S_T2:    t_state = 6'b000010;
        S_T3:    t_state = 6'b000100;
        S_T4:    t_state = 6'b001000;
        S_T5:    t_state = 6'b010000;
        S_T6:    t_state = 6'b100000;
        default: t_state = '0;
      endcase
    end
  end

  assign instr_done = clr_ && last_state;
  assign halted     = (state_q == S_HALT);

endmodule
